// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RISC-V write-back stage with load extraction and retired-instruction counter
module wb_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic                 mem_reg_we_i,
  input  logic [4:0]           mem_rd_addr_i,
  input  logic [1:0]           mem_wb_sel_i,
  input  logic [2:0]           mem_funct3_i,
  input  logic [31:0]          mem_alu_result_i,
  input  logic [31:0]          mem_pc_plus4_i,
  input  logic [31:0]          dmem_rdata_i,
  input  logic                 dmem_rvalid_i,
  output logic                 wb_reg_we_o,
  output logic [4:0]           wb_rd_addr_o,
  output logic [31:0]          wb_rd_data_o,
  output logic                 load_err_o,
  output logic [INSTRET_W-1:0] instret_o
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [0:0]  state;
  logic [4:0]  ld_rd;
  logic        ld_we;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_lane;

  logic [31:0] ld_data;
  logic        ld_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_ready_o = (state == IDLE);

  // Lane extraction from the aligned word; error covers misalignment and unused funct3 codes.
  always_comb begin
    ld_data = 32'h0;
    ld_err  = 1'b0;
    ld_byte = 8'(dmem_rdata_i >> {ld_lane, 3'b000});
    ld_half = ld_lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (ld_funct3)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {24'h0, ld_byte};
      3'b001: begin
        ld_data = {{16{ld_half[15]}}, ld_half};
        ld_err  = ld_lane[0];
      end
      3'b101: begin
        ld_data = {16'h0, ld_half};
        ld_err  = ld_lane[0];
      end
      3'b010: begin
        ld_data = dmem_rdata_i;
        ld_err  = (ld_lane != 2'b00);
      end
      default: ld_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wb_reg_we_o  <= 1'b0;
      wb_rd_addr_o <= 5'd0;
      wb_rd_data_o <= 32'h0;
      load_err_o   <= 1'b0;
      instret_o    <= '0;
      ld_rd        <= 5'd0;
      ld_we        <= 1'b0;
      ld_funct3    <= 3'b0;
      ld_lane      <= 2'b0;
    end else begin
      wb_reg_we_o <= 1'b0;
      load_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid_i) begin
            if (mem_wb_sel_i == SEL_LOAD) begin
              ld_rd     <= mem_rd_addr_i;
              ld_we     <= mem_reg_we_i;
              ld_funct3 <= mem_funct3_i;
              ld_lane   <= mem_alu_result_i[1:0];
              state     <= LOAD_WAIT;
            end else begin
              wb_reg_we_o  <= mem_reg_we_i & (mem_rd_addr_i != 5'd0);
              wb_rd_addr_o <= mem_rd_addr_i;
              wb_rd_data_o <= (mem_wb_sel_i == SEL_PC4) ? mem_pc_plus4_i : mem_alu_result_i;
              instret_o    <= instret_o + 1'b1;
            end
          end
        end
        default: begin
          if (dmem_rvalid_i) begin
            // Faulting loads retire without touching the write port.
            if (ld_err) begin
              load_err_o <= 1'b1;
            end else begin
              wb_reg_we_o  <= ld_we & (ld_rd != 5'd0);
              wb_rd_addr_o <= ld_rd;
              wb_rd_data_o <= ld_data;
            end
            instret_o <= instret_o + 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        mem_reg_we_i;
  logic [4:0]  mem_rd_addr_i;
  logic [1:0]  mem_wb_sel_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_alu_result_i;
  logic [31:0] mem_pc_plus4_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_rvalid_i;
  logic        wb_reg_we_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_rd_data_o;
  logic        load_err_o;
  logic [63:0] instret_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_reg_we_i(mem_reg_we_i), .mem_rd_addr_i(mem_rd_addr_i),
    .mem_wb_sel_i(mem_wb_sel_i), .mem_funct3_i(mem_funct3_i),
    .mem_alu_result_i(mem_alu_result_i), .mem_pc_plus4_i(mem_pc_plus4_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
    .wb_reg_we_o(wb_reg_we_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_rd_data_o(wb_rd_data_o), .load_err_o(load_err_o),
    .instret_o(instret_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                         input logic we, input logic [31:0] alu, input logic [31:0] pc4);
    mem_valid_i      = 1'b1;
    mem_wb_sel_i     = sel;
    mem_funct3_i     = f3;
    mem_rd_addr_i    = rd;
    mem_reg_we_i     = we;
    mem_alu_result_i = alu;
    mem_pc_plus4_i   = pc4;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_valid_i = 1'b0; mem_reg_we_i = 1'b0; mem_rd_addr_i = 5'd0;
    mem_wb_sel_i = 2'b00; mem_funct3_i = 3'b000; mem_alu_result_i = 32'h0;
    mem_pc_plus4_i = 32'h0; dmem_rdata_i = 32'h0; dmem_rvalid_i = 1'b0;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (mem_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", mem_ready_o); end
    n_cmp++; if (wb_reg_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b exp 0", wb_reg_we_o); end
    n_cmp++; if (wb_rd_addr_o !== 5'd0) begin n_bad++; $display("FAIL reset_addr got %0d exp 0", wb_rd_addr_o); end
    n_cmp++; if (wb_rd_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h exp 0", wb_rd_data_o); end
    n_cmp++; if (load_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", load_err_o); end
    n_cmp++; if (instret_o !== 64'd0) begin n_bad++; $display("FAIL reset_instret got %0d exp 0", instret_o); end
  endtask

  task automatic test_back_to_back();
    present(2'b00, 3'b000, 5'd5, 1'b1, 32'h0000_0010, 32'h0);
    step();
    n_cmp++; if (wb_reg_we_o !== 1'b1) begin n_bad++; $display("FAIL alu_we got %b exp 1", wb_reg_we_o); end
    n_cmp++; if (wb_rd_addr_o !== 5'd5) begin n_bad++; $display("FAIL alu_addr got %0d exp 5", wb_rd_addr_o); end
    n_cmp++; if (wb_rd_data_o !== 32'h10) begin n_bad++; $display("FAIL alu_data got %h exp 00000010", wb_rd_data_o); end
    n_cmp++; if (instret_o !== 64'd1) begin n_bad++; $display("FAIL alu_instret got %0d exp 1", instret_o); end
    present(2'b10, 3'b000, 5'd1, 1'b1, 32'hDEAD_0000, 32'h0000_0104);
    step();
    n_cmp++; if (wb_rd_data_o !== 32'h104) begin n_bad++; $display("FAIL link_data got %h exp 00000104", wb_rd_data_o); end
    n_cmp++; if (wb_reg_we_o !== 1'b1 || wb_rd_addr_o !== 5'd1) begin n_bad++; $display("FAIL link_we_addr got %b/%0d exp 1/1", wb_reg_we_o, wb_rd_addr_o); end
    present(2'b00, 3'b000, 5'd0, 1'b1, 32'h0000_0055, 32'h0);
    step();
    n_cmp++; if (wb_reg_we_o !== 1'b0) begin n_bad++; $display("FAIL x0_we got %b exp 0", wb_reg_we_o); end
    n_cmp++; if (instret_o !== 64'd3) begin n_bad++; $display("FAIL x0_instret got %0d exp 3", instret_o); end
    present(2'b11, 3'b000, 5'd7, 1'b1, 32'h0000_ABCD, 32'h0000_0999);
    step();
    mem_valid_i = 1'b0;
    n_cmp++; if (wb_rd_data_o !== 32'hABCD || wb_reg_we_o !== 1'b1) begin n_bad++; $display("FAIL sel11_data got %h/%b exp 0000abcd/1", wb_rd_data_o, wb_reg_we_o); end
    step();
    n_cmp++; if (wb_reg_we_o !== 1'b0 || wb_rd_data_o !== 32'hABCD) begin n_bad++; $display("FAIL idle_hold got %b/%h exp 0/0000abcd", wb_reg_we_o, wb_rd_data_o); end
  endtask

  task automatic test_load_lb();
    present(2'b01, 3'b000, 5'd3, 1'b1, 32'h0000_1003, 32'h0);
    step();
    mem_valid_i = 1'b0;
    n_cmp++; if (wb_reg_we_o !== 1'b0) begin n_bad++; $display("FAIL lb_accept_we got %b exp 0", wb_reg_we_o); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem_ready_o !== 1'b0) begin n_bad++; $display("FAIL lb_wait_ready cyc %0d got %b exp 0", i, mem_ready_o); end
      if (i < 2) step();
    end
    dmem_rdata_i = 32'h80FF_1234; dmem_rvalid_i = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    n_cmp++; if (wb_rd_data_o !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h exp ffffff80", wb_rd_data_o); end
    n_cmp++; if (wb_reg_we_o !== 1'b1 || wb_rd_addr_o !== 5'd3) begin n_bad++; $display("FAIL lb_we_addr got %b/%0d exp 1/3", wb_reg_we_o, wb_rd_addr_o); end
    n_cmp++; if (instret_o !== 64'd5 || mem_ready_o !== 1'b1) begin n_bad++; $display("FAIL lb_instret_ready got %0d/%b exp 5/1", instret_o, mem_ready_o); end
    dmem_rvalid_i = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    n_cmp++; if (wb_reg_we_o !== 1'b0 || instret_o !== 64'd5) begin n_bad++; $display("FAIL idle_rvalid got %b/%0d exp 0/5", wb_reg_we_o, instret_o); end
  endtask

  task automatic test_load_half();
    present(2'b01, 3'b101, 5'd4, 1'b1, 32'h0000_2002, 32'h0);
    step();
    mem_valid_i = 1'b0; dmem_rdata_i = 32'h8001_0000; dmem_rvalid_i = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    n_cmp++; if (wb_rd_data_o !== 32'h0000_8001 || wb_reg_we_o !== 1'b1) begin n_bad++; $display("FAIL lhu_data got %h/%b exp 00008001/1", wb_rd_data_o, wb_reg_we_o); end
    present(2'b01, 3'b001, 5'd9, 1'b1, 32'h0000_2000, 32'h0);
    step();
    mem_valid_i = 1'b0; dmem_rdata_i = 32'h1234_F00F; dmem_rvalid_i = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    n_cmp++; if (wb_rd_data_o !== 32'hFFFF_F00F || instret_o !== 64'd7) begin n_bad++; $display("FAIL lh_data got %h/%0d exp fffff00f/7", wb_rd_data_o, instret_o); end
  endtask

  task automatic test_load_err();
    present(2'b01, 3'b010, 5'd6, 1'b1, 32'h0000_3001, 32'h0);
    step();
    mem_valid_i = 1'b0; dmem_rdata_i = 32'hCAFE_BABE; dmem_rvalid_i = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    n_cmp++; if (load_err_o !== 1'b1 || wb_reg_we_o !== 1'b0) begin n_bad++; $display("FAIL lw_misalign got err %b we %b exp 1/0", load_err_o, wb_reg_we_o); end
    n_cmp++; if (instret_o !== 64'd8) begin n_bad++; $display("FAIL lw_misalign_instret got %0d exp 8", instret_o); end
    step();
    n_cmp++; if (load_err_o !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %b exp 0", load_err_o); end
    present(2'b01, 3'b011, 5'd6, 1'b1, 32'h0000_3000, 32'h0);
    step();
    mem_valid_i = 1'b0; dmem_rvalid_i = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    n_cmp++; if (load_err_o !== 1'b1 || wb_reg_we_o !== 1'b0 || instret_o !== 64'd9) begin n_bad++; $display("FAIL bad_funct3 got err %b we %b ir %0d exp 1/0/9", load_err_o, wb_reg_we_o, instret_o); end
  endtask

  task automatic test_reset_in_wait();
    present(2'b01, 3'b010, 5'd8, 1'b1, 32'h0000_4000, 32'h0);
    step();
    mem_valid_i = 1'b0; rst = 1'b1; dmem_rdata_i = 32'h1111_2222; dmem_rvalid_i = 1'b1;
    step();
    rst = 1'b0;
    step();
    dmem_rvalid_i = 1'b0;
    n_cmp++; if (wb_reg_we_o !== 1'b0 || mem_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_wait we/ready got %b/%b exp 0/1", wb_reg_we_o, mem_ready_o); end
    n_cmp++; if (instret_o !== 64'd0 || wb_rd_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_wait instret/data got %0d/%h exp 0/0", instret_o, wb_rd_data_o); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_lb();
    test_load_half();
    test_load_err();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
